// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg : shared widths, opcode constants and FSM encoding for alu_ctrl  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package alu_pkg;

  localparam int BITS_DEFAULT      = 32;
  localparam int SIG_COUNT_DEFAULT = 12;
  localparam int OP_W              = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV = 4'd3;
  localparam logic [OP_W-1:0] OP_SHR = 4'd4;
  localparam logic [OP_W-1:0] OP_SHL = 4'd5;
  localparam logic [OP_W-1:0] OP_ROR = 4'd6;
  localparam logic [OP_W-1:0] OP_ROL = 4'd7;
  localparam logic [OP_W-1:0] OP_AND = 4'd8;
  localparam logic [OP_W-1:0] OP_OR  = 4'd9;
  localparam logic [OP_W-1:0] OP_NEG = 4'd10;
  localparam logic [OP_W-1:0] OP_NOT = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_EXEC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_op_decode : opcode -> one-hot ALU control, long-op and illegal flags |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int SIG_COUNT = SIG_COUNT_DEFAULT
) (
  input  logic [OP_W-1:0]      i_op,
  output logic [SIG_COUNT-1:0] o_ctrl,
  output logic                 o_is_long,
  output logic                 o_illegal
);

  always_comb begin
    o_is_long = 1'b0;
    o_illegal = 1'b0;
    unique case (i_op)
      OP_MUL, OP_DIV: o_is_long = 1'b1;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_NEG, OP_NOT: o_is_long = 1'b0;
      default: o_illegal = 1'b1;
    endcase
  end

  // Control bit index equals the opcode value.
  for (genvar i = 0; i < SIG_COUNT; i++) begin : g_onehot
    assign o_ctrl[i] = !o_illegal && (i_op == OP_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/alu_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_controller : request/response sequencer for an external ALU         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_controller
  import alu_pkg::*;
#(
  parameter int BITS      = BITS_DEFAULT,
  parameter int SIG_COUNT = SIG_COUNT_DEFAULT,
  parameter int LONG_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OP_W-1:0]      req_op,
  input  logic [BITS-1:0]      req_a,
  input  logic [BITS-1:0]      req_b,
  output logic [SIG_COUNT-1:0] alu_ctrl,
  output logic [BITS-1:0]      alu_x,
  output logic [BITS-1:0]      alu_y,
  input  logic [2*BITS-1:0]    alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS-1:0]      rsp_lo,
  output logic [BITS-1:0]      rsp_hi,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam logic [3:0] LONG_CNT = 4'(LONG_WAIT - 1);

  state_t                 state_q, state_d;
  logic [OP_W-1:0]        op_q, op_d;
  logic [BITS-1:0]        a_q, a_d, b_q, b_d;
  logic [BITS-1:0]        lo_q, lo_d, hi_q, hi_d;
  logic                   err_q, err_d;
  logic [3:0]             cnt_q, cnt_d;

  logic [OP_W-1:0]        dec_op;
  logic [SIG_COUNT-1:0]   dec_ctrl;
  logic                   dec_long;
  logic                   dec_illegal;
  logic                   div_by_zero;

  // One decoder serves both the incoming opcode (in IDLE) and the latched one.
  assign dec_op      = (state_q == ST_IDLE) ? req_op : op_q;
  assign div_by_zero = (req_op == OP_DIV) && (req_b == '0);

  alu_op_decode #(
    .SIG_COUNT (SIG_COUNT)
  ) u_decode (
    .i_op      (dec_op),
    .o_ctrl    (dec_ctrl),
    .o_is_long (dec_long),
    .o_illegal (dec_illegal)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          if (dec_illegal || div_by_zero) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            lo_d    = '0;
            hi_d    = '0;
          end else begin
            state_d = ST_LOAD;
            err_d   = 1'b0;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_EXEC;
        cnt_d   = dec_long ? LONG_CNT : 4'd0;
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CAPTURE: begin
        lo_d    = alu_result[BITS-1:0];
        hi_d    = dec_long ? alu_result[2*BITS-1:BITS] : '0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state register so reset clears them at once.
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_ctrl  = ((state_q == ST_EXEC) || (state_q == ST_CAPTURE)) ? dec_ctrl : '0;
  assign alu_x     = a_q;
  assign alu_y     = b_q;
  assign rsp_lo    = lo_q;
  assign rsp_hi    = hi_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_controller : transaction-level model plus random/directed stimulus|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_controller;

  localparam int BITS = 32;
  localparam int SIG  = 12;
  localparam int LW   = 4;

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [3:0]      req_op = 4'd0;
  logic [31:0]     req_a = 32'd0;
  logic [31:0]     req_b = 32'd0;
  logic [11:0]     alu_ctrl;
  logic [31:0]     alu_x, alu_y;
  logic [63:0]     alu_result;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [31:0]     rsp_lo, rsp_hi;
  logic            rsp_err;
  logic            busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_controller #(.BITS(BITS), .SIG_COUNT(SIG), .LONG_WAIT(LW)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference ALU; short ops put a junk pattern in the high half.
  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [4:0]  s;
    logic [5:0]  t;
    logic signed [63:0] p;
    logic signed [31:0] q, m;
    s = b[4:0];
    t = 6'd32 - {1'b0, s};
    r = 32'd0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      4'd3: begin
        if (b == 32'd0) return 64'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = $signed(a) / $signed(b);
        m = $signed(a) % $signed(b);
        return {m, q};
      end
      4'd4:  r = a >> s;
      4'd5:  r = a << s;
      4'd6:  r = (a >> s) | (a << t);
      4'd7:  r = (a << s) | (a >> t);
      4'd8:  r = a & b;
      4'd9:  r = a | b;
      4'd10: r = -a;
      4'd11: r = ~a;
      default: r = 32'd0;
    endcase
    return {r ^ 32'hA5A5_5A5A, r};
  endfunction

  always_comb begin
    alu_result = 64'hDEAD_BEEF_0BAD_F00D;
    for (int i = 0; i < 12; i++)
      if (alu_ctrl == (12'h1 << i)) alu_result = alu_fn(4'(i), alu_x, alu_y);
  end

  // ---------------- behavioural model ----------------
  function automatic bit f_err(input logic [3:0] op, input logic [31:0] b);
    return (op > 4'd11) || (op == 4'd3 && b == 32'd0);
  endfunction
  function automatic bit f_long(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd3);
  endfunction

  bit          m_busy = 1'b0;
  int          m_age, m_lat;
  logic [3:0]  m_op;
  logic        m_err;
  logic [31:0] m_a, m_b, m_lo, m_hi;

  // m_age counts edges since accept; the response is due when m_age reaches m_lat.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        logic [63:0] f;
        f = alu_fn(req_op, req_a, req_b);
        m_busy <= 1'b1;
        m_age  <= 0;
        m_op   <= req_op;
        m_a    <= req_a;
        m_b    <= req_b;
        m_err  <= f_err(req_op, req_b);
        m_lat  <= f_err(req_op, req_b) ? 0 : (f_long(req_op) ? LW : 1) + 2;
        m_lo   <= f_err(req_op, req_b) ? 32'd0 : f[31:0];
        m_hi   <= (f_err(req_op, req_b) || !f_long(req_op)) ? 32'd0 : f[63:32];
      end
    end else if (m_age == m_lat) begin
      if (rsp_ready) m_busy <= 1'b0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    logic [11:0] ec;
    if (clr) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_alu_ctrl", alu_ctrl, 0);
      chk("rst_alu_xy", {alu_x, alu_y}, 0);
      chk("rst_rsp_data", {rsp_hi, rsp_lo}, 0);
    end else if (!m_busy) begin
      chk("idle_req_ready", req_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_alu_ctrl", alu_ctrl, 0);
    end else begin
      ec = (!m_err && m_age >= 1 && m_age <= m_lat - 1) ? (12'h1 << m_op) : 12'h0;
      chk("busy", busy, 1);
      chk("req_ready", req_ready, 0);
      chk("rsp_valid", rsp_valid, (m_age == m_lat) ? 1 : 0);
      chk("alu_ctrl", alu_ctrl, ec);
      if (!m_err && m_age < m_lat) chk("alu_xy", {alu_x, alu_y}, {m_a, m_b});
      if (m_age == m_lat) begin
        chk("rsp_lo", rsp_lo, m_lo);
        chk("rsp_hi", rsp_hi, m_hi);
        chk("rsp_err", rsp_err, m_err);
      end
    end
  end

  // ---------------- directed helpers ----------------
  int          ctrl_cycles;
  logic [11:0] ctrl_or;
  always @(negedge clk) begin
    if (alu_ctrl != 12'h0) begin
      ctrl_cycles++;
      ctrl_or |= alu_ctrl;
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int   g;
    logic ok;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    g = 0;
    do begin
      ok = req_ready;
      @(posedge clk);
      g++;
    end while (!ok && g < 50);
    #1;
    req_valid   = 1'b0;
    ctrl_cycles = 0;
    ctrl_or     = 12'h0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // Waits for the response, optionally stalls rsp_ready while poking req_valid.
  task automatic get_resp(input int hold, input logic [31:0] hold_lo,
                          output logic [31:0] lo, output logic [31:0] hi,
                          output logic err, output int edges);
    edges = 0;
    while (!rsp_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
    end
    if (!rsp_valid) chk("resp_timeout", 0, 1);
    lo = rsp_lo; hi = rsp_hi; err = rsp_err;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1; req_op = 4'd0; req_a = 32'd1; req_b = 32'd1;
      @(posedge clk);
      #1;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_rsp_lo", rsp_lo, hold_lo);
      chk("hold_rsp_hi", rsp_hi, 0);
      chk("hold_rsp_err", rsp_err, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [31:0] lo, hi;
    logic        err;
    int          ed;
    bit          saw_rsp;

    #1 clr = 1'b1;
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_lo", rsp_lo, 0);
    @(posedge clk); @(posedge clk); #1 clr = 1'b0;
    @(posedge clk); #1;

    send(4'd0, 32'd15, 32'd5);
    get_resp(0, 32'd0, lo, hi, err, ed);
    chk("add_lo", lo, 32'd20);
    chk("add_hi", hi, 32'd0);
    chk("add_err", err, 0);
    chk("add_latency", ed, 3);
    chk("add_ctrl_val", ctrl_or, 12'h001);
    chk("add_ctrl_cycles", ctrl_cycles, 2);

    send(4'd2, -32'sd15, 32'd5);
    get_resp(0, 32'd0, lo, hi, err, ed);
    chk("mul_lo", lo, 32'hFFFF_FFB5);
    chk("mul_hi", hi, 32'hFFFF_FFFF);
    chk("mul_latency", ed, 6);
    chk("mul_ctrl_val", ctrl_or, 12'h004);
    chk("mul_ctrl_cycles", ctrl_cycles, 5);   // 4 EXEC + CAPTURE

    send(4'd3, 32'd15, 32'd0);
    chk("div0_valid_next_cycle", rsp_valid, 1);
    get_resp(0, 32'd0, lo, hi, err, ed);
    chk("div0_err", err, 1);
    chk("div0_lo", lo, 32'd0);
    chk("div0_hi", hi, 32'd0);
    chk("div0_ctrl_cycles", ctrl_cycles, 0);

    send(4'd13, 32'd7, 32'd7);
    get_resp(0, 32'd0, lo, hi, err, ed);
    chk("illegal_err", err, 1);
    send(4'd5, 32'd16, 32'd2);
    get_resp(0, 32'd0, lo, hi, err, ed);
    chk("shl_lo", lo, 32'd64);
    chk("shl_err", err, 0);

    send(4'd1, 32'd100, 32'd58);
    get_resp(3, 32'd42, lo, hi, err, ed);
    chk("sub_lo", lo, 32'd42);
    chk("after_handshake_busy", busy, 0);

    send(4'd2, 32'd7, 32'd9);
    @(posedge clk); @(posedge clk); #1;
    chk("clr_pre_ctrl", alu_ctrl, 12'h004);
    #2 clr = 1'b1;
    #1;
    chk("clr_async_ctrl", alu_ctrl, 0);
    chk("clr_async_busy", busy, 0);
    chk("clr_async_req_ready", req_ready, 1);
    @(posedge clk); #1 clr = 1'b0;
    saw_rsp = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    rsp_ready = 1'b0;
    chk("clr_no_response", saw_rsp, 0);
    send(4'd0, 32'd1, 32'd2);
    get_resp(0, 32'd0, lo, hi, err, ed);
    chk("post_clr_add_lo", lo, 32'd3);
    chk("post_clr_add_latency", ed, 3);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 4'($urandom_range(0, 15));
      req_a     = $urandom;
      req_b     = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rsp_ready = $urandom_range(0, 1) == 1;
      if (i % 400 == 250) begin
        #2 clr = 1'b1;
        #1 clr = 1'b0;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
